slice_sequencer: RTL

SLICE_SEQUENCER -- requirements
Module: slice_sequencer

---
 rtl/slice_pkg.sv | 20 ++
 rtl/slice_select.sv | 31 +++
 rtl/slice_sequencer.sv | 116 +++++++++++
 3 files changed

// File: rtl/slice_pkg.sv
// rtl/slice_pkg.sv - shared types and helpers for the slice sequencer
//
// Purpose: sequencer FSM state encoding and the slice-index width helper,
// shared by slice_sequencer and slice_select.
// Ports: none (package).

package slice_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  // Index width for n slices. This is never narrower than one bit, so a
  // single-slice operand still gets a real index port.
  function automatic int idx_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/slice_select.sv
// rtl/slice_select.sv - combinational S-bit slice picker
//
// Purpose: returns slice idx of a packed vector of N slices of S bits each.
//          Slice i occupies bits [(i+1)*S-1 : i*S].
// Ports:
//   vec   in  N*S    packed operand
//   idx   in  IDX_W  slice index; out-of-range values yield zero
//   slice out S      selected slice

module slice_select
  import slice_pkg::*;
#(
  parameter int S     = 4,
  parameter int N     = 2,
  parameter int IDX_W = idx_w(N)
) (
  input  logic [N*S-1:0]   vec,
  input  logic [IDX_W-1:0] idx,
  output logic [S-1:0]     slice
);

  // A compare-per-slice mux keeps non-power-of-two N safe: unused index
  // codes fall through to zero instead of reading past the vector.
  always_comb begin
    slice = '0;
    for (int i = 0; i < N; i++) begin
      if (int'(idx) == i) slice = vec[i*S +: S];
    end
  end

endmodule

// File: rtl/slice_sequencer.sv
// rtl/slice_sequencer.sv - streams operand pairs out as per-slice beats
//
// Purpose: accepts an operand pair (A, B) with a direction flag and emits
//          N_A beats, one S-bit slice of each operand per beat, LSB slice
//          first (reverse=0) or MSB slice first (reverse=1). A new pair can
//          be accepted on the last beat, giving back-to-back operation.
// Ports:
//   clk, rst             clock, asynchronous active-high reset
//   in_valid, in_ready   operand handshake
//   A, B, reverse        operands and ordering, sampled on acceptance
//   out_valid, out_ready beat handshake
//   a_slice, b_slice     current slices of A and B
//   slice_idx            physical index of the current slice
//   first, last          beat is the first / last of the operation

module slice_sequencer
  import slice_pkg::*;
#(
  parameter  int S     = 4,
  parameter  int N_A   = 2,
  localparam int IDX_W = idx_w(N_A)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [N_A*S-1:0]   A,
  input  logic [N_A*S-1:0]   B,
  input  logic               reverse,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [S-1:0]       a_slice,
  output logic [S-1:0]       b_slice,
  output logic [IDX_W-1:0]   slice_idx,
  output logic               first,
  output logic               last
);

  localparam logic [IDX_W-1:0] LAST_CNT = IDX_W'(N_A - 1);

  state_t               state, state_nxt;
  logic [IDX_W-1:0]     cnt, cnt_nxt;
  logic [N_A*S-1:0]     a_q, b_q;
  logic                 reverse_q;
  logic                 load;

  assign first     = (cnt == '0);
  assign last      = (cnt == LAST_CNT);
  assign slice_idx = reverse_q ? (LAST_CNT - cnt) : cnt;

  // Handshake and next-state logic. in_ready is gated by rst so nothing is
  // offered while the block is held in reset. Acceptance is evaluated last
  // so a load on the final beat overrides the return to IDLE.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    load      = 1'b0;

    case (state)
      IDLE: begin
        in_ready = !rst;
      end
      SEND: begin
        out_valid = 1'b1;
        in_ready  = !rst && last && out_ready;
        if (out_ready) begin
          if (last) state_nxt = IDLE;
          else      cnt_nxt   = cnt + 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase

    if (in_valid && in_ready) begin
      load      = 1'b1;
      state_nxt = SEND;
      cnt_nxt   = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt       <= '0;
      a_q       <= '0;
      b_q       <= '0;
      reverse_q <= 1'b0;
    end else begin
      cnt <= cnt_nxt;
      if (load) begin
        a_q       <= A;
        b_q       <= B;
        reverse_q <= reverse;
      end
    end
  end

  slice_select #(.S(S), .N(N_A), .IDX_W(IDX_W)) u_sel_a (
    .vec   (a_q),
    .idx   (slice_idx),
    .slice (a_slice)
  );

  slice_select #(.S(S), .N(N_A), .IDX_W(IDX_W)) u_sel_b (
    .vec   (b_q),
    .idx   (slice_idx),
    .slice (b_slice)
  );

endmodule
